// File: rtl/vga_timing_monitor_if.sv
// Video sync/blank inputs and measured timing outputs of vga_timing_monitor.
interface vga_timing_monitor_if;
  logic        hs;
  logic        vs;
  logic        blank_n;
  logic [11:0] h_total;
  logic [11:0] h_active;
  logic [10:0] v_total;
  logic [10:0] v_active;
  logic        locked;
  logic        mismatch;
  logic        no_signal;
  logic        hs_pol;
  logic        vs_pol;

  modport master (
    output hs, vs, blank_n,
    input  h_total, h_active, v_total, v_active, locked, mismatch, no_signal, hs_pol, vs_pol
  );

  modport slave (
    input  hs, vs, blank_n,
    output h_total, h_active, v_total, v_active, locked, mismatch, no_signal, hs_pol, vs_pol
  );
endinterface

// File: rtl/vga_timing_monitor.sv
// Measures incoming VGA line/frame timing and locks once it is stable.
// Optional sync polarity detection: define VGA_MON_POLARITY_DETECT_EN.
module vga_timing_monitor #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned H_TIMEOUT   = 4095
) (
  input  logic                 vga_clk,
  input  logic                 reset,
  vga_timing_monitor_if.slave  vid
);
  localparam int unsigned MW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam int unsigned TW = (H_TIMEOUT < 2) ? 1 : $clog2(H_TIMEOUT + 1);

  typedef enum logic [1:0] {SEEK, MEASURE, VERIFY, LOCKED} state_t;
  state_t state_q;

  logic          hs_q, vs_q, blank_q, hs_p_q, vs_p_q;
  logic          hs_pol_q, vs_pol_q, pol_change;
  logic          hs_lead, vs_lead, timeout, frame_same;
  logic [11:0]   line_cnt_q, act_cnt_q, line_len, line_act;
  logic [11:0]   f_htot_q, f_hact_q, f_htot_d, f_hact_d;
  logic [10:0]   f_vtot_q, f_vact_q, f_vtot_d, f_vact_d;
  logic          f_irreg_q, f_irreg_d;
  logic [11:0]   c_htot_q, c_hact_q, h_total_q, h_active_q;
  logic [10:0]   c_vtot_q, c_vact_q, v_total_q, v_active_q;
  logic [MW-1:0] match_q;
  logic [TW-1:0] idle_q, idle_d;
  logic          locked_q, mismatch_q, no_signal_q;

`ifdef VGA_MON_POLARITY_DETECT_EN
  logic blank_p_q;
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank_p_q <= 1'b0;
      hs_pol_q  <= 1'b0;
      vs_pol_q  <= 1'b0;
    end else begin
      blank_p_q <= blank_q;
      if (blank_q && !blank_p_q) begin
        hs_pol_q <= ~hs_q;
        vs_pol_q <= ~vs_q;
      end
    end
  end
  assign pol_change = blank_q && !blank_p_q && ((hs_pol_q == hs_q) || (vs_pol_q == vs_q));
`else
  assign hs_pol_q   = 1'b0;
  assign vs_pol_q   = 1'b0;
  assign pol_change = 1'b0;
`endif

  assign hs_lead = (hs_q == hs_pol_q) && (hs_p_q != hs_pol_q);
  assign vs_lead = (vs_q == vs_pol_q) && (vs_p_q != vs_pol_q);

  // Frame statistics after folding in the line closed this cycle, so a
  // simultaneous VS edge sees the line already counted.
  always_comb begin
    line_len  = (line_cnt_q == '1) ? '1 : line_cnt_q + 12'd1;
    line_act  = (act_cnt_q == '1 || !blank_q) ? act_cnt_q : act_cnt_q + 12'd1;
    f_htot_d  = f_htot_q;
    f_hact_d  = f_hact_q;
    f_vtot_d  = f_vtot_q;
    f_vact_d  = f_vact_q;
    f_irreg_d = f_irreg_q;
    if (hs_lead) begin
      f_vtot_d = (f_vtot_q == '1) ? '1 : f_vtot_q + 11'd1;
      if (f_vtot_q == '0) f_htot_d = line_len;
      else if (line_len != f_htot_q) f_irreg_d = 1'b1;
      if (line_act != '0) begin
        f_vact_d = (f_vact_q == '1) ? '1 : f_vact_q + 11'd1;
        if (f_hact_q == '0) f_hact_d = line_act;
        else if (line_act != f_hact_q) f_irreg_d = 1'b1;
      end
    end
    frame_same = !f_irreg_d && (f_htot_d == c_htot_q) && (f_hact_d == c_hact_q) &&
                 (f_vtot_d == c_vtot_q) && (f_vact_d == c_vact_q);
    idle_d  = hs_lead ? '0 : ((idle_q == TW'(H_TIMEOUT)) ? idle_q : idle_q + 1'b1);
    timeout = !hs_lead && (idle_d == TW'(H_TIMEOUT));
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q <= SEEK;
      {hs_q, vs_q, blank_q, hs_p_q, vs_p_q} <= '0;
      {line_cnt_q, act_cnt_q, idle_q} <= '0;
      {f_htot_q, f_hact_q, f_vtot_q, f_vact_q, f_irreg_q} <= '0;
      {c_htot_q, c_hact_q, c_vtot_q, c_vact_q, match_q} <= '0;
      {h_total_q, h_active_q, v_total_q, v_active_q} <= '0;
      {locked_q, mismatch_q, no_signal_q} <= '0;
    end else begin
      {hs_q, vs_q, blank_q} <= {vid.hs, vid.vs, vid.blank_n};
      hs_p_q      <= hs_q;
      vs_p_q      <= vs_q;
      idle_q      <= idle_d;
      no_signal_q <= timeout || (no_signal_q && !hs_lead);
      mismatch_q  <= 1'b0;
      line_cnt_q  <= hs_lead ? '0 : line_len;
      act_cnt_q   <= hs_lead ? '0 : line_act;
      if (vs_lead) begin
        {f_htot_q, f_hact_q, f_vtot_q, f_vact_q, f_irreg_q} <= '0;
      end else begin
        {f_htot_q, f_hact_q, f_vtot_q, f_vact_q, f_irreg_q} <=
          {f_htot_d, f_hact_d, f_vtot_d, f_vact_d, f_irreg_d};
      end

      if (timeout || pol_change) begin
        state_q  <= SEEK;
        locked_q <= 1'b0;
        match_q  <= '0;
        if (timeout) begin
          {line_cnt_q, act_cnt_q} <= '0;
          {f_htot_q, f_hact_q, f_vtot_q, f_vact_q, f_irreg_q} <= '0;
        end
      end else if (vs_lead) begin
        case (state_q)
          SEEK: state_q <= MEASURE;
          MEASURE: begin
            {c_htot_q, c_hact_q, c_vtot_q, c_vact_q} <= {f_htot_d, f_hact_d, f_vtot_d, f_vact_d};
            match_q <= '0;
            state_q <= VERIFY;
          end
          VERIFY: begin
            if (frame_same) begin
              match_q <= match_q + 1'b1;
              if ((32'(match_q) + 32'd1) >= LOCK_FRAMES) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                {h_total_q, h_active_q, v_total_q, v_active_q} <=
                  {c_htot_q, c_hact_q, c_vtot_q, c_vact_q};
              end
            end else begin
              {c_htot_q, c_hact_q, c_vtot_q, c_vact_q} <= {f_htot_d, f_hact_d, f_vtot_d, f_vact_d};
              match_q <= '0;
            end
          end
          LOCKED: begin
            if (!frame_same) begin
              mismatch_q <= 1'b1;
              locked_q   <= 1'b0;
              {c_htot_q, c_hact_q, c_vtot_q, c_vact_q} <= {f_htot_d, f_hact_d, f_vtot_d, f_vact_d};
              match_q    <= '0;
              state_q    <= VERIFY;
            end
          end
          default: state_q <= SEEK;
        endcase
      end
    end
  end

  assign vid.h_total   = h_total_q;
  assign vid.h_active  = h_active_q;
  assign vid.v_total   = v_total_q;
  assign vid.v_active  = v_active_q;
  assign vid.locked    = locked_q;
  assign vid.mismatch  = mismatch_q;
  assign vid.no_signal = no_signal_q;
  assign vid.hs_pol    = hs_pol_q;
  assign vid.vs_pol    = vs_pol_q;
endmodule

// File: doc/vga_timing_monitor.md
VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

Interface
REQ-001 Parameter LOCK_FRAMES, default 2: number of consecutive matching frames, after the measured frame, required before lock.
REQ-002 Parameter H_TIMEOUT, default 4095: vga_clk cycles without an HS leading edge that declare loss of signal.
REQ-003 vga_clk  input  1  pixel clock; sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 hs, vs  input  1 each  incoming horizontal and vertical sync.
REQ-006 blank_n  input  1  incoming active-video qualifier; 1 = visible pixel.
REQ-007 h_total  output  12  vga_clk cycles per line.
REQ-008 h_active  output  12  blank_n=1 cycles per line.
REQ-009 v_total  output  11  lines per frame.
REQ-010 v_active  output  11  lines per frame containing at least one blank_n=1 cycle.
REQ-011 locked  output  1  measured timing stable and valid.
REQ-012 mismatch  output  1  one-cycle pulse when a frame differs from the captured timing.
REQ-013 no_signal  output  1  level; high while the HS timeout condition holds.
REQ-014 hs_pol, vs_pol  output  1 each  detected sync polarity, 1 = active-high.

Function
REQ-015 hs, vs and blank_n SHALL each pass through one input register before any use.
REQ-016 The leading edge SHALL be the transition into the active sync level: falling for active-low, rising for active-high.
REQ-017 Line counter: clears at each registered HS leading edge; the count at that edge, including the edge cycle, is the line length; saturates at 12'hFFF.
REQ-018 Active counter: counts registered blank_n=1 cycles within the current line; saturates at 12'hFFF.
REQ-019 Line counters: count HS leading edges, and lines with an active cycle, between VS leading edges; both saturate at 11'h7FF.
REQ-020 Simultaneous HS and VS leading edges: the line SHALL be closed and counted first, then the frame SHALL be closed.
REQ-021 FSM states: SEEK, MEASURE, VERIFY, LOCKED.
REQ-022 SEEK: wait for a VS leading edge, then go to MEASURE.
REQ-023 MEASURE: at the next VS leading edge, capture the frame's four values into the candidate registers and go to VERIFY with the match count at 0.
REQ-024 VERIFY, at each VS leading edge: if all four values equal the candidate, increment the match count; on reaching LOCK_FRAMES, go to LOCKED.
REQ-025 VERIFY, at each VS leading edge: on any difference, recapture the values into the candidate, clear the match count, and stay in VERIFY.
REQ-026 LOCKED, at each VS leading edge: on any difference, pulse mismatch for one cycle, drop locked, recapture the candidate, and go to VERIFY.
REQ-027 h_total, h_active, v_total and v_active SHALL update only on entry to LOCKED and hold their values while locked is low.
REQ-028 Latency: locked rises 2 vga_clk cycles after the input vs transition that completes the final matching frame.
REQ-029 On H_TIMEOUT cycles without an HS leading edge, from any state: assert no_signal, drop locked, clear all counters, and go to SEEK.
REQ-030 no_signal SHALL deassert on the next HS leading edge.

Reset
REQ-031 While reset=1, the FSM SHALL be in SEEK with all counters, candidate registers and match count cleared.
REQ-032 Output reset values: all measurement outputs 0; locked=0; mismatch=0; no_signal=0; hs_pol=0; vs_pol=0.
REQ-033 Reset asserted mid-frame SHALL discard all partial measurements; the first VS leading edge after reset only enters MEASURE.

Configuration
REQ-034 Macro VGA_MON_POLARITY_DETECT_EN.
REQ-035 With VGA_MON_POLARITY_DETECT_EN defined: at each registered blank_n rising edge, hs_pol and vs_pol SHALL be set to the inverse of the registered hs and vs levels.
REQ-036 With VGA_MON_POLARITY_DETECT_EN defined: edge detection (REQ-016) SHALL use the detected polarity, and any change in detected polarity SHALL force SEEK.
REQ-037 Without VGA_MON_POLARITY_DETECT_EN: hs_pol and vs_pol SHALL be tied to 0, and active-low sync SHALL be assumed.

Verification
REQ-038 640x480 source, active-low sync, 800x525 total, LOCK_FRAMES=2 -> after 3 full frames from the first VS edge: locked=1, h_total=800, h_active=640, v_total=525, v_active=480.
REQ-039 While locked, change one line's length to 801 -> mismatch high for exactly one cycle at the next VS edge; locked=0; locked returns after 2 further clean frames.
REQ-040 Hold hs constant for 4095 cycles -> no_signal=1 and locked=0; restore hs -> no_signal=0 at the first HS leading edge; locked follows REQ-038 timing.
REQ-041 Assert reset for 1 cycle mid-frame while locked -> all outputs 0 on the next cycle; relock after a full SEEK/MEASURE/VERIFY sequence.
REQ-042 With VGA_MON_POLARITY_DETECT_EN, active-high sync, 640x480 timing -> hs_pol=1, vs_pol=1, locked=1 with the same values as REQ-038; without the macro -> hs_pol=0, vs_pol=0.
